// File: rtl/load_store_unit.sv
// Load/store unit: accepts one core memory request at a time, checks funct3
// legality and alignment, issues a single word-aligned bus access with byte
// enables, and returns a registered, extended response with an error flag.
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    // Counter only needs to reach TIMEOUT-1; one spare bit keeps TIMEOUT
    // values that are exact powers of two representable.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) + 1 : 1;
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT_R = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             we_q, we_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [1:0]       addr_lo_q, addr_lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [3:0]       mem_be_q, mem_be_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic [31:0]      rsp_rdata_q, rsp_rdata_d;
    logic             rsp_err_q, rsp_err_d;

    logic             handshake;
    logic             req_ok;
    logic [3:0]       fmt_be;
    logic [31:0]      fmt_wdata;
    logic [31:0]      lane;
    logic [31:0]      load_data;
    logic             timeout_hit;

    assign req_ready = resetn && (state_q == IDLE);
    assign handshake = req_valid && req_ready;
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // The last allowed cycle of ISSUE+WAIT_R has been reached.
    assign timeout_hit = (TIMEOUT > 0) && (cnt_q == TO_LAST);

    // Decode the incoming request: legality, alignment, byte enables and lane replication.
    always_comb begin
        logic legal;
        logic misal;
        legal     = 1'b0;
        misal     = 1'b0;
        fmt_be    = 4'b1111;
        fmt_wdata = req_wdata;
        case (req_funct3)
            3'b000: legal = 1'b1;
            3'b001: begin
                legal = 1'b1;
                misal = req_addr[0];
            end
            3'b010: begin
                legal = 1'b1;
                misal = |req_addr[1:0];
            end
            3'b100: legal = !req_we;
            3'b101: begin
                legal = !req_we;
                misal = req_addr[0];
            end
            default: legal = 1'b0;
        endcase
        req_ok = legal && !misal;
        case (req_funct3[1:0])
            2'b00: begin
                fmt_be    = 4'b0001 << req_addr[1:0];
                fmt_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                fmt_be    = 4'b0011 << req_addr[1:0];
                fmt_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                fmt_be    = 4'b1111;
                fmt_wdata = req_wdata;
            end
        endcase
    end

    // Select the addressed lane of the read word and sign/zero-extend it.
    always_comb begin
        lane      = mem_rdata >> {addr_lo_q, 3'b000};
        load_data = lane;
        case (funct3_q)
            3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_data = {24'd0, lane[7:0]};
            3'b101:  load_data = {16'd0, lane[15:0]};
            default: load_data = lane;
        endcase
    end

    // Next-state and next-register logic for the request/response sequence.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        addr_lo_d   = addr_lo_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (handshake) begin
                    we_d      = req_we;
                    funct3_d  = req_funct3;
                    addr_lo_d = req_addr[1:0];
                    cnt_d     = '0;
                    if (req_ok) begin
                        state_d     = ISSUE;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_we;
                        mem_be_d    = fmt_be;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_wdata_d = fmt_wdata;
                    end else begin
                        // Rejected requests never touch the bus.
                        state_d     = RESP;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'd0;
                    end
                end
            end
            ISSUE: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    if (we_q) begin
                        state_d     = RESP;
                        rsp_err_d   = 1'b0;
                        rsp_rdata_d = 32'd0;
                    end else begin
                        state_d = WAIT_R;
                    end
                end else if (timeout_hit) begin
                    mem_req_d   = 1'b0;
                    state_d     = RESP;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = 32'd0;
                end
            end
            WAIT_R: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_rvalid) begin
                    state_d     = RESP;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = load_data;
                end else if (timeout_hit) begin
                    state_d     = RESP;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = 32'd0;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            funct3_q    <= 3'd0;
            addr_lo_q   <= 2'd0;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'd0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            addr_lo_q   <= addr_lo_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: TIMEOUT, default 16, max cycles spent in ISSUE plus WAIT_R before forced error completion; 0 disables the timeout.
REQ-002 SHALL have port: clk  in  1  rising-edge clock for all state.
REQ-003 SHALL have port: resetn  in  1  reset, synchronous, active-low.
REQ-004 SHALL have ports: req_valid  in  1  core request; req_ready  out  1  LSU can accept.
REQ-005 SHALL have ports: req_we  in  1  1=store, 0=load; req_funct3  in  3  RISC-V width code.
REQ-006 SHALL have ports: req_addr  in  32  effective address from the ALU result; req_wdata  in  32  store data (rs2).
REQ-007 SHALL have ports: rsp_valid  out  1  completion pulse; rsp_rdata  out  32  extended load data; rsp_err  out  1  error flag.
REQ-008 SHALL have ports: mem_req, mem_we  out  1 each; mem_be  out  4; mem_addr  out  32  word aligned; mem_wdata  out  32.
REQ-009 SHALL have ports: mem_gnt  in  1  request accepted; mem_rvalid  in  1  read data valid; mem_rdata  in  32.

Function
REQ-010 SHALL use FSM states IDLE, ISSUE, WAIT_R, RESP.
REQ-011 SHALL drive req_ready=1 only in IDLE with resetn high; handshake = req_valid & req_ready.
REQ-012 On handshake SHALL register we, funct3, addr[1:0] and req_wdata, then decode and check the request.
REQ-013 Legal funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW; all other codes are illegal.
REQ-014 Misaligned: halfword with addr[0]=1; word with addr[1:0]!=00.
REQ-015 Illegal or misaligned request SHALL go IDLE->RESP with rsp_err=1 and rsp_rdata=0, and SHALL NOT assert mem_req.
REQ-016 Legal request SHALL go IDLE->ISSUE.
REQ-017 In ISSUE, mem_req SHALL be 1, with mem_addr={addr[31:2],2'b00} and mem_we, mem_be, mem_wdata held stable until mem_gnt.
REQ-018 mem_be: byte -> 4'b0001<<addr[1:0]; half -> 4'b0011<<addr[1:0]; word -> 4'b1111; mem_be SHALL be driven for loads too.
REQ-019 mem_wdata: SB replicates byte to all lanes; SH replicates half to both halves; SW passes data unchanged.
REQ-020 ISSUE with mem_gnt=1: store SHALL go to RESP; load SHALL go to WAIT_R. mem_rvalid SHALL be ignored in ISSUE and IDLE.
REQ-021 WAIT_R with mem_rvalid=1 SHALL capture data and go to RESP; mem_req SHALL be 0 in WAIT_R.
REQ-022 Load data SHALL be taken from the addressed lane (mem_rdata >> 8*addr[1:0]).
REQ-023 LB/LH SHALL sign-extend, LBU/LHU SHALL zero-extend, and LW SHALL pass through.
REQ-024 Timeout counter SHALL clear on handshake and count each cycle in ISSUE/WAIT_R.
REQ-025 On reaching TIMEOUT (if TIMEOUT>0), the block SHALL go to RESP with rsp_err=1 and rsp_rdata=0, dropping mem_req.
REQ-026 RESP SHALL assert rsp_valid for exactly one cycle, then go to IDLE.
REQ-027 rsp_rdata SHALL be 0 for stores.
REQ-028 rsp_rdata and rsp_err SHALL be registered and SHALL hold their values until the next RESP.
REQ-029 No back-pressure on rsp; the minimum period between accepted requests is 3 cycles for stores and 4 cycles for loads.
REQ-030 Latency from handshake cycle N with zero-wait memory: store rsp_valid at N+2; load (gnt at N+1, rvalid at N+2) rsp_valid at N+3; error rsp_valid at N+1.

Reset
REQ-031 resetn=0 at a clock edge SHALL force IDLE and clear the counter and captured fields.
REQ-032 resetn=0 at a clock edge SHALL zero rsp_valid, rsp_rdata, rsp_err, mem_req, mem_we, mem_be, mem_addr and mem_wdata.
REQ-033 req_ready SHALL be 0 while resetn=0.
REQ-034 Reset mid-transaction SHALL abandon the access with no rsp_valid pulse; late mem_gnt or mem_rvalid after reset SHALL be ignored.

Verification
REQ-035 SB addr=0x1003 wdata=0x000000AB, gnt immediate -> mem_addr=0x1000, be=1000, wdata=0xABABABAB; rsp_valid at N+2, err=0.
REQ-036 LH addr=0x2002, mem_rdata=0x8001_1234 -> rsp_rdata=0xFFFF8001; LHU same stimulus -> 0x00008001; rsp_valid at N+3.
REQ-037 LW addr=0x3001 -> rsp_valid at N+1, rsp_err=1, rsp_rdata=0, mem_req never asserted; funct3=011 load gives the same result.
REQ-038 Load with mem_gnt held low and TIMEOUT=16 -> mem_req high 16 cycles, then rsp_err=1 and req_ready returns 1 in the following cycle.
REQ-039 LB addr=0x4001, gnt delayed 3 cycles, rvalid 2 cycles after gnt, mem_rdata=0x0000_7F00 -> mem outputs stable throughout; rsp_rdata=0x0000007F.
REQ-040 resetn low for 1 cycle while in WAIT_R, then rvalid asserted -> no rsp_valid, state IDLE, req_ready=1 the cycle after reset is released.
